instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage for the RV64I single-cycle core. It sits directly downstream of the program counter: it reads `pc_current` and fetches the 32-bit instruction over a request/grant/response instruction-memory bus. It presents the instruction to decode for exactly one cycle. It drives `fetch_stall`, which the core ORs into the PC's `halted` input so the PC holds until the fetch completes. Misaligned PCs, bus errors and timeouts are trapped as sticky faults.

## Interface
- `TIMEOUT_CYCLES`, default 255: consecutive REQ+WAIT cycles without a response before a timeout fault; legal range 2..65535.
- `clk` in 1: rising-edge clock.
- `reset` in 1: reset is asynchronous and active-high.
- `pc_current` in 64: PC to fetch; stable while `fetch_stall`=1.
- `core_halted` in 1: core stopped (e.g. EBREAK); stops new fetches.
- `imem_req` out 1: request valid.
- `imem_addr` out 64: request address.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response valid.
- `imem_rdata` in 32: response instruction word.
- `imem_err` in 1: response carries a bus error (qualified by `imem_rvalid`).
- `instr` out 32: latched instruction.
- `instr_pc` out 64: address of `instr`, or of the faulting fetch.
- `instr_valid` out 1: `instr` is valid for the core this cycle.
- `fetch_stall` out 1: hold PC.
- `fault` out 1: sticky fetch fault.
- `fault_cause` out 2: 0 none, 1 misaligned, 2 bus error, 3 timeout.
- `fetch_count` out 32: instructions delivered; wraps.

## Operation
- States:
  - IDLE, REQ, WAIT, DELIVER, FAULT.
  - Reset enters IDLE.
- IDLE: `fetch_stall`=1.
  - Next state is REQ if `core_halted`=0, else stay in IDLE.
- REQ:
  - Entry clears the timeout counter.
  - `imem_addr`=`pc_current`; `instr_pc` is captured on the first REQ cycle.
  - If `pc_current[1:0]`≠0: `imem_req`=0 and next state is FAULT with cause 1. No bus request is ever issued for a misaligned PC.
  - Otherwise `imem_req`=1 and is held with a stable address until `imem_gnt`=1; grant moves to WAIT.
- WAIT:
  - `imem_rvalid`=1 with `imem_err`=0: latch `imem_rdata` into `instr` and go to DELIVER.
  - `imem_rvalid`=1 with `imem_err`=1: go to FAULT with cause 2; `instr` is not updated.
- DELIVER:
  - `instr_valid`=1 and `fetch_stall`=0 for exactly one cycle; the PC advances at the end of this cycle.
  - `fetch_count` increments (2^32−1 wraps to 0).
  - Next state is REQ if `core_halted`=0, else IDLE.
- FAULT:
  - `fault`=1 and `fetch_stall`=1; `fault_cause` and `instr_pc` are held.
  - No requests are issued. Only reset exits FAULT.
- Timeout:
  - The counter increments every cycle spent in REQ or WAIT.
  - If the TIMEOUT_CYCLES-th such cycle ends without grant+response completing (no `imem_rvalid` in WAIT), next state is FAULT with cause 3.
  - A response arriving in that same final cycle wins over the timeout.
- `imem_rvalid` while in IDLE, REQ, DELIVER or FAULT is ignored. The bus guarantees the response comes no earlier than the cycle after grant, and at most one request is outstanding.
- `core_halted` is sampled only in IDLE and DELIVER. An outstanding request always runs to completion (DELIVER or FAULT).
- Reset mid-transaction: immediate return to IDLE and all outputs cleared. The memory is reset by the same signal, so no stale response is expected.

## Timing
- Reset values:
  - State IDLE.
  - `imem_req`=0, `imem_addr`=0.
  - `instr`=0, `instr_pc`=0, `instr_valid`=0.
  - `fetch_stall`=1.
  - `fault`=0, `fault_cause`=0, `fetch_count`=0.
- `imem_addr` is combinational from `pc_current`, gated to 0 outside REQ. All other outputs are registered or state-decoded.
- Best case (grant in the first REQ cycle, response the next cycle): REQ, WAIT, DELIVER, which is 3 cycles per instruction.
  - Steady state: `instr_valid` pulses every 3 cycles.
- First fetch after reset release: IDLE(1), REQ, WAIT, DELIVER, so the earliest `instr_valid` is in cycle 4 after reset deassertion.
- Each additional cycle of grant or response delay adds exactly one stall cycle.

## Test plan
- Reset, `pc_current`=0x0, zero-wait memory returning 0x00000013 → `imem_req` for one cycle at addr 0x0; `instr_valid`=1 in cycle 4 with `instr`=0x00000013, `instr_pc`=0x0, `fetch_count`=1.
- Back-to-back fetches from 0x1000, 0x1004, 0x1008, grant delayed 2 cycles on the second fetch → `instr_valid` spacing 3, 5, 3 cycles; `imem_addr` stable while `imem_req`=1 without grant.
- `pc_current`=0x1002 → no `imem_req` ever asserted; `fault`=1, `fault_cause`=1, `instr_pc`=0x1002; state persists until reset.
- Response with `imem_err`=1 at 0x2000 → `fault_cause`=2, `instr` unchanged from the previous fetch, no further requests.
- `TIMEOUT_CYCLES`=8, grant given but no response → `fault_cause`=3 after exactly 8 REQ+WAIT cycles. Response in the 8th cycle → DELIVER, no fault.
- `core_halted` raised during WAIT → current instruction delivered, then IDLE with `fetch_stall`=1 and `imem_req`=0; lowering it resumes with REQ. Reset asserted mid-WAIT → all outputs take their reset values asynchronously.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RV64I fetch stage: request/grant/response imem bus, one-cycle delivery, sticky faults
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_current,
    input  logic        core_halted,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    output logic        fetch_stall,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DELIVER,
        S_FAULT
    } state_t;

    localparam logic [1:0]  CAUSE_MISALIGNED = 2'd1;
    localparam logic [1:0]  CAUSE_BUS_ERR    = 2'd2;
    localparam logic [1:0]  CAUSE_TIMEOUT    = 2'd3;
    localparam logic [15:0] TCNT_LAST        = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] tcnt;
    logic        aligned;
    logic        timeout;

    assign aligned = (pc_current[1:0] == 2'b00);
    // tcnt holds the number of REQ/WAIT cycles already completed, so this
    // flags the TIMEOUT_CYCLES-th cycle while it is still in progress.
    assign timeout = (tcnt == TCNT_LAST);

    assign imem_req    = (state == S_REQ) && aligned;
    assign imem_addr   = (state == S_REQ) ? pc_current : 64'd0;
    assign instr_valid = (state == S_DELIVER);
    assign fetch_stall = (state != S_DELIVER);
    assign fault       = (state == S_FAULT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            tcnt        <= 16'd0;
            instr       <= 32'd0;
            instr_pc    <= 64'd0;
            fault_cause <= 2'd0;
            fetch_count <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!core_halted) begin
                        state <= S_REQ;
                        tcnt  <= 16'd0;
                    end
                end
                S_REQ: begin
                    // pc_current is held by the stall, so every REQ cycle sees the same value
                    instr_pc <= pc_current;
                    if (!aligned) begin
                        state       <= S_FAULT;
                        fault_cause <= CAUSE_MISALIGNED;
                    end else if (timeout) begin
                        state       <= S_FAULT;
                        fault_cause <= CAUSE_TIMEOUT;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                        if (imem_gnt) begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid && !imem_err) begin
                        instr       <= imem_rdata;
                        fetch_count <= fetch_count + 32'd1;
                        state       <= S_DELIVER;
                    end else if (imem_rvalid) begin
                        state       <= S_FAULT;
                        fault_cause <= CAUSE_BUS_ERR;
                    end else if (timeout) begin
                        state       <= S_FAULT;
                        fault_cause <= CAUSE_TIMEOUT;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                S_DELIVER: begin
                    if (!core_halted) begin
                        state <= S_REQ;
                        tcnt  <= 16'd0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] pc_current = 64'd0;
    logic        core_halted = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_err = 1'b0;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        fetch_stall;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fetch_count;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    instr_fetch_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_current  (pc_current),
        .core_halted (core_halted),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_err    (imem_err),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .fetch_stall (fetch_stall),
        .fault       (fault),
        .fault_cause (fault_cause),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reset is released just after a rising edge so the next full cycle is the IDLE cycle;
    // returns at the negedge inside that IDLE cycle.
    task automatic apply_reset(input logic [63:0] pc);
        @(negedge clk);
        reset = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_err = 1'b0;
        core_halted = 1'b0;
        pc_current = pc;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    // Memory side of one transaction; entered at a negedge, returns at the negedge after the response.
    task automatic serve(input int gd, input logic [63:0] exp_addr, input logic [31:0] d, input logic e);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
            mismatched++;
            $display("FAIL serve_req: req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, exp_addr);
        end
        for (int i = 0; i < gd; i++) begin
            @(negedge clk);
            compared++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
                mismatched++;
                $display("FAIL addr_stable: req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, exp_addr);
            end
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = d;
        imem_err = e;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_err = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        compared++;
        if ({imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_stall, fault, fault_cause, fetch_count}
            !== {1'b0, 64'd0, 32'd0, 64'd0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0}) begin
            mismatched++;
            $display("FAIL reset_values: req=%b addr=%h instr=%h pc=%h v=%b stall=%b f=%b c=%0d cnt=%0d expected 0s with stall=1",
                     imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_stall, fault, fault_cause, fetch_count);
        end
        apply_reset(64'h0);
        compared++;
        if (fetch_stall !== 1'b1 || imem_req !== 1'b0) begin
            mismatched++;
            $display("FAIL first_idle: stall=%b req=%b expected stall=1 req=0", fetch_stall, imem_req);
        end
        @(negedge clk);
        compared++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            mismatched++;
            $display("FAIL first_req: req=%b addr=%h expected 1 / 0", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        compared++;
        if (imem_req !== 1'b0) begin
            mismatched++;
            $display("FAIL req_one_cycle: req=%b expected 0", imem_req);
        end
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0000_0013;
        @(negedge clk);
        imem_rvalid = 1'b0;
        compared++;
        if (instr_valid !== 1'b1 || instr !== 32'h13 || instr_pc !== 64'h0 || fetch_count !== 32'd1 || fetch_stall !== 1'b0) begin
            mismatched++;
            $display("FAIL first_deliver: v=%b instr=%h pc=%h cnt=%0d stall=%b expected 1 00000013 0 1 0",
                     instr_valid, instr, instr_pc, fetch_count, fetch_stall);
        end
        @(negedge clk);
        compared++;
        if (instr_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL valid_one_cycle: v=%b expected 0", instr_valid);
        end
    endtask

    task automatic test_back_to_back();
        int t[4];
        logic [63:0] pcs [4];
        int gds [4];
        int exp_gap [3];
        pcs = '{64'h0FFC, 64'h1000, 64'h1004, 64'h1008};
        gds = '{0, 0, 2, 0};
        exp_gap = '{3, 5, 3};
        apply_reset(pcs[0]);
        for (int k = 0; k < 4; k++) begin
            serve(gds[k], pcs[k], 32'hA000_0000 + 32'(k), 1'b0);
            t[k] = cyc;
            compared++;
            if (instr_valid !== 1'b1 || instr !== 32'hA000_0000 + 32'(k) || instr_pc !== pcs[k] || fetch_count !== 32'(k + 1)) begin
                mismatched++;
                $display("FAIL b2b_deliver%0d: v=%b instr=%h pc=%h cnt=%0d expected 1 %h %h %0d",
                         k, instr_valid, instr, instr_pc, fetch_count, 32'hA000_0000 + 32'(k), pcs[k], k + 1);
            end
            if (k < 3) pc_current = pcs[k + 1];
        end
        for (int k = 0; k < 3; k++) begin
            compared++;
            if (t[k + 1] - t[k] != exp_gap[k]) begin
                mismatched++;
                $display("FAIL b2b_spacing%0d: got %0d cycles expected %0d", k, t[k + 1] - t[k], exp_gap[k]);
            end
        end
    endtask

    task automatic test_misaligned();
        int reqs;
        reqs = 0;
        apply_reset(64'h1002);
        for (int i = 0; i < 20; i++) begin
            if (imem_req !== 1'b0) reqs++;
            @(negedge clk);
        end
        compared++;
        if (reqs != 0) begin
            mismatched++;
            $display("FAIL misaligned_noreq: saw %0d request cycles expected 0", reqs);
        end
        compared++;
        if (fault !== 1'b1 || fault_cause !== 2'd1 || instr_pc !== 64'h1002 || fetch_stall !== 1'b1) begin
            mismatched++;
            $display("FAIL misaligned_fault: f=%b c=%0d pc=%h stall=%b expected 1 1 1002 1", fault, fault_cause, instr_pc, fetch_stall);
        end
    endtask

    task automatic test_bus_error();
        int reqs;
        reqs = 0;
        apply_reset(64'h1FFC);
        serve(0, 64'h1FFC, 32'hAAAA_5555, 1'b0);
        pc_current = 64'h2000;
        serve(0, 64'h2000, 32'hDEAD_BEEF, 1'b1);
        compared++;
        if (fault !== 1'b1 || fault_cause !== 2'd2 || instr !== 32'hAAAA_5555 || instr_pc !== 64'h2000) begin
            mismatched++;
            $display("FAIL bus_err: f=%b c=%0d instr=%h pc=%h expected 1 2 aaaa5555 2000", fault, fault_cause, instr, instr_pc);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req !== 1'b0) reqs++;
        end
        compared++;
        if (reqs != 0 || fault !== 1'b1) begin
            mismatched++;
            $display("FAIL bus_err_hold: reqs=%0d f=%b expected 0 1", reqs, fault);
        end
    endtask

    task automatic test_timeout();
        apply_reset(64'h3000);
        @(negedge clk);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge clk);
        compared++;
        if (fault !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_early: f=%b expected 0 in 8th cycle", fault);
        end
        @(negedge clk);
        compared++;
        if (fault !== 1'b1 || fault_cause !== 2'd3 || instr_pc !== 64'h3000) begin
            mismatched++;
            $display("FAIL timeout_fault: f=%b c=%0d pc=%h expected 1 3 3000", fault, fault_cause, instr_pc);
        end
        apply_reset(64'h3000);
        @(negedge clk);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_rvalid = 1'b0;
        compared++;
        if (instr_valid !== 1'b1 || fault !== 1'b0 || instr !== 32'h1234_5678) begin
            mismatched++;
            $display("FAIL timeout_last_rsp: v=%b f=%b instr=%h expected 1 0 12345678", instr_valid, fault, instr);
        end
    endtask

    task automatic test_halt_and_reset();
        int reqs;
        reqs = 0;
        apply_reset(64'h4000);
        @(negedge clk);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        core_halted = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0010_0073;
        @(negedge clk);
        imem_rvalid = 1'b0;
        compared++;
        if (instr_valid !== 1'b1 || instr !== 32'h0010_0073) begin
            mismatched++;
            $display("FAIL halt_deliver: v=%b instr=%h expected 1 00100073", instr_valid, instr);
        end
        pc_current = 64'h4004;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (imem_req !== 1'b0 || fetch_stall !== 1'b1) reqs++;
        end
        compared++;
        if (reqs != 0) begin
            mismatched++;
            $display("FAIL halt_idle: %0d bad cycles expected 0", reqs);
        end
        core_halted = 1'b0;
        @(negedge clk);
        compared++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h4004) begin
            mismatched++;
            $display("FAIL halt_resume: req=%b addr=%h expected 1 4004", imem_req, imem_addr);
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        reset = 1'b1;
        #1;
        compared++;
        if ({imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_stall, fault, fault_cause, fetch_count}
            !== {1'b0, 64'd0, 32'd0, 64'd0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0}) begin
            mismatched++;
            $display("FAIL reset_mid_wait: req=%b addr=%h instr=%h pc=%h v=%b stall=%b f=%b c=%0d cnt=%0d expected reset values",
                     imem_req, imem_addr, instr, instr_pc, instr_valid, fetch_stall, fault, fault_cause, fetch_count);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_misaligned();
        test_bus_error();
        test_timeout();
        test_halt_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
